dcache_port_arbiter: RTL and testbench

Sequences the single data-cache request port between the two execute-stage memory slots (slot 0 older, slot 1 younger) in program order. It registers each request, runs the dcache handshake (addr_ok, then data_ok), and returns per-slot completion pulses. It stalls the execute stage until every valid slot in the current issue group has completed. It sits between the two ALUs and the dcache master interface and replaces the valid-priority mux at that point.

---
 rtl/dcache_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// Serialises the two execute-stage memory slots onto the single dcache port in program order.
// Optional performance counters are built only when DCACHE_ARB_PERF_EN is defined.
module dcache_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [1:0]                   req_valid,
  input  logic [1:0]                   req_op,
  input  logic [1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]   req_wdata,
  input  logic [1:0][DATA_WIDTH/8-1:0] req_wstrb,
  output logic [1:0]                   req_done,
  output logic [DATA_WIDTH-1:0]        resp_rdata,
  output logic                         pause_arb,
  output logic                         dcache_valid,
  output logic                         dcache_op,
  output logic [ADDR_WIDTH-1:0]        dcache_addr,
  output logic [DATA_WIDTH-1:0]        dcache_wdata,
  output logic [DATA_WIDTH/8-1:0]      dcache_wstrb,
  input  logic                         dcache_addr_ok,
  input  logic                         dcache_data_ok,
  input  logic [DATA_WIDTH-1:0]        dcache_rdata,
  output logic [31:0]                  perf_dual_cnt,
  output logic [31:0]                  perf_stall_cnt
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_cur;
  logic [1:0]            r_served;
  logic                  r_dvalid;
  logic                  r_dop;
  logic [ADDR_WIDTH-1:0] r_daddr;
  logic [DATA_WIDTH-1:0] r_dwdata;
  logic [STRB_W-1:0]     r_dwstrb;

  logic [1:0]            w_cand;
  logic                  w_done;
  logic                  w_issue;
  logic                  w_sel;
  logic                  w_pause;

  assign w_cand = req_valid & ~r_served;
  assign w_done = (r_state == S_WAIT) & dcache_data_ok & ~flush;

  // Completing slot 0 with slot 1 still pending chains straight into slot 1's request,
  // saving the idle bubble between the two accesses of a dual group.
  assign w_issue = ((r_state == S_IDLE) & (|w_cand) & ~flush)
                 | (w_done & ~r_cur & w_cand[1]);
  assign w_sel   = (r_state == S_IDLE) ? ~w_cand[0] : 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (dcache_addr_ok)  w_state_nxt = flush ? S_DRAIN : S_WAIT;
        else if (flush)      w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (flush)               w_state_nxt = dcache_data_ok ? S_IDLE : S_DRAIN;
        else if (dcache_data_ok) w_state_nxt = w_issue ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (dcache_data_ok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req_done   = w_done ? (r_cur ? 2'b10 : 2'b01) : 2'b00;
  assign resp_rdata = w_done ? dcache_rdata : '0;
  assign w_pause    = (|(req_valid & ~r_served & ~req_done)) | (r_state == S_DRAIN);
  assign pause_arb  = w_pause;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cur    <= 1'b0;
      r_served <= 2'b00;
      r_dvalid <= 1'b0;
      r_dop    <= 1'b0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_dwstrb <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dvalid <= (w_state_nxt == S_REQ);
      if (w_issue) begin
        r_cur    <= w_sel;
        r_dop    <= req_op[w_sel];
        r_daddr  <= req_addr[w_sel];
        r_dwdata <= req_wdata[w_sel];
        r_dwstrb <= req_wstrb[w_sel];
      end
      // The group retires whenever the stall drops, so completion flags only live while stalled.
      if (flush | ~w_pause)  r_served        <= 2'b00;
      else if (w_done)       r_served[r_cur] <= 1'b1;
    end
  end

  assign dcache_valid = r_dvalid;
  assign dcache_op    = r_dop;
  assign dcache_addr  = r_daddr;
  assign dcache_wdata = r_dwdata;
  assign dcache_wstrb = r_dwstrb;

`ifdef DCACHE_ARB_PERF_EN
  logic        w_dual_sel;
  logic [31:0] r_dual_cnt;
  logic [31:0] r_stall_cnt;

  assign w_dual_sel = (r_state == S_IDLE) & w_issue & (&req_valid) & (r_served == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dual_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_dual_sel) r_dual_cnt  <= r_dual_cnt + 32'd1;
      if (w_pause)    r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_dual_cnt  = r_dual_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`else
  assign perf_dual_cnt  = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios plus randomized groups, flushes and cache latency,
// checked against a transaction-level model of the port's ordering and stall rules.
module tb_dcache_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [1:0]           req_valid;
  logic [1:0]           req_op;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][DW-1:0]   req_wdata;
  logic [1:0][SW-1:0]   req_wstrb;
  logic [1:0]           req_done;
  logic [DW-1:0]        resp_rdata;
  logic                 pause_arb;
  logic                 dcache_valid;
  logic                 dcache_op;
  logic [AW-1:0]        dcache_addr;
  logic [DW-1:0]        dcache_wdata;
  logic [SW-1:0]        dcache_wstrb;
  logic                 dcache_addr_ok;
  logic                 dcache_data_ok;
  logic [DW-1:0]        dcache_rdata;
  logic [31:0]          perf_dual_cnt;
  logic [31:0]          perf_stall_cnt;

  dcache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_done(req_done), .resp_rdata(resp_rdata), .pause_arb(pause_arb),
    .dcache_valid(dcache_valid), .dcache_op(dcache_op), .dcache_addr(dcache_addr),
    .dcache_wdata(dcache_wdata), .dcache_wstrb(dcache_wstrb),
    .dcache_addr_ok(dcache_addr_ok), .dcache_data_ok(dcache_data_ok),
    .dcache_rdata(dcache_rdata),
    .perf_dual_cnt(perf_dual_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: what the pipeline/cache pair has observed at transaction level.
  bit       m_out;      // an accepted access is awaiting data_ok
  bit       m_kill;     // that access was flushed and must be discarded
  int       m_slot;     // slot owning the outstanding access
  bit [1:0] m_comp;     // slots of the current group already completed
  bit       m_dv_exp;   // expected dcache_valid this cycle
  bit       m_chg;      // pipeline may present a new group next cycle
  int       m_dual;
  int       m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_slot(input int s, input bit op, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    req_op[s]    = op;
    req_addr[s]  = a;
    req_wdata[s] = wd;
    req_wstrb[s] = ws;
  endtask

  task automatic model_reset();
    m_out = 0; m_kill = 0; m_slot = 0; m_comp = 0; m_dv_exp = 0; m_chg = 1;
    m_dual = 0; m_stall = 0;
  endtask

  // One cycle: inputs are already applied; check at the falling edge, advance the model,
  // and return 1 time unit after the next rising edge.
  task automatic step();
    logic [1:0] exp_done;
    bit exp_pause, pend, completion, drain_end, nxt;
    int es;
    @(negedge clk);
    exp_done = 2'b00;
    if (m_out && dcache_data_ok && !m_kill && !flush) exp_done[m_slot] = 1'b1;
    exp_pause = (|(req_valid & ~m_comp & ~exp_done)) || (m_out && m_kill);
    chk("req_done",     32'(req_done),     32'(exp_done));
    chk("resp_rdata",   resp_rdata,        (exp_done != 2'b00) ? dcache_rdata : 32'd0);
    chk("pause_arb",    32'(pause_arb),    32'(exp_pause));
    chk("dcache_valid", 32'(dcache_valid), 32'(m_dv_exp));
    es = (req_valid[0] && !m_comp[0]) ? 0 : 1;
    if (dcache_valid) begin
      pend = req_valid[es] && !m_comp[es];
      chk("issue_pending", 32'(pend),         32'd1);
      chk("issue_op",      32'(dcache_op),    32'(req_op[es]));
      chk("issue_addr",    dcache_addr,       req_addr[es]);
      chk("issue_wdata",   dcache_wdata,      req_wdata[es]);
      chk("issue_wstrb",   32'(dcache_wstrb), 32'(req_wstrb[es]));
    end
    if (exp_pause) m_stall++;
    completion = (exp_done != 2'b00);
    drain_end  = m_out && dcache_data_ok && (m_kill || flush);
    if (m_out && dcache_data_ok) begin
      m_out  = 0;
      m_kill = 0;
      m_comp = m_comp | exp_done;
    end else if (m_out && flush) begin
      m_kill = 1;
    end
    if (dcache_valid && dcache_addr_ok) begin
      m_out  = 1;
      m_slot = es;
      m_kill = flush;
    end
    nxt = !flush && !m_out && (|(req_valid & ~m_comp)) && !drain_end;
    if (!m_dv_exp && nxt && !completion && req_valid == 2'b11 && m_comp == 2'b00) m_dual++;
    m_dv_exp = nxt;
    if (flush || !exp_pause) begin
      m_comp = 2'b00;
      m_chg  = 1;
    end else begin
      m_chg  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Act as a zero-wait cache until the current group retires, bounded by a cycle budget.
  task automatic finish_group(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      flush          = 1'b0;
      dcache_addr_ok = dcache_valid;
      dcache_data_ok = m_out;
      dcache_rdata   = $urandom;
      step();
      if (m_chg) begin
        ok = 1;
        break;
      end
    end
    chk("group_retire_timeout", 32'(ok), 32'd1);
    req_valid = 2'b00; dcache_addr_ok = 1'b0; dcache_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; req_valid = 2'b00; req_op = 2'b00;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    dcache_addr_ok = 1'b0; dcache_data_ok = 1'b0; dcache_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dvalid", 32'(dcache_valid), 32'd0);
    chk("rst_addr",   dcache_addr,       32'd0);
    chk("rst_wdata",  dcache_wdata,      32'd0);
    chk("rst_done",   32'(req_done),     32'd0);
    chk("rst_rdata",  resp_rdata,        32'd0);
    chk("rst_pause",  32'(pause_arb),    32'd0);
    chk("rst_pdual",  perf_dual_cnt,     32'd0);
    chk("rst_pstall", perf_stall_cnt,    32'd0);
    rst = 1'b1;

    // single load, best case
    set_slot(0, 1'b0, 32'h1000, 32'd0, 4'h0); req_valid = 2'b01;
    step();
    chk("single_dvalid", 32'(dcache_valid), 32'd1);
    chk("single_addr",   dcache_addr,       32'h1000);
    dcache_addr_ok = 1'b1; step();
    dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'hDEADBEEF; #1;
    chk("single_done",  32'(req_done),  32'd1);
    chk("single_rdata", resp_rdata,     32'hDEADBEEF);
    chk("single_pause", 32'(pause_arb), 32'd0);
    step();
    dcache_data_ok = 1'b0; req_valid = 2'b00; step();

    // dual: store then load, in order
    set_slot(0, 1'b1, 32'h2000, 32'h11223344, 4'hF);
    set_slot(1, 1'b0, 32'h2000, 32'd0, 4'h0);
    req_valid = 2'b11;
    step();
    chk("dual_first_op",    32'(dcache_op),    32'd1);
    chk("dual_first_wdata", dcache_wdata,      32'h11223344);
    chk("dual_first_wstrb", 32'(dcache_wstrb), 32'hF);
    dcache_addr_ok = 1'b1; step();
    dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'd0; #1;
    chk("dual_done0",  32'(req_done),  32'd1);
    chk("dual_pause0", 32'(pause_arb), 32'd1);
    step();
    dcache_data_ok = 1'b0;
    chk("dual_second_dvalid", 32'(dcache_valid), 32'd1);
    chk("dual_second_op",     32'(dcache_op),    32'd0);
    dcache_addr_ok = 1'b1; step();
    dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'hA5A50F0F; #1;
    chk("dual_done1",  32'(req_done),  32'd2);
    chk("dual_rdata1", resp_rdata,     32'hA5A50F0F);
    chk("dual_pause1", 32'(pause_arb), 32'd0);
    step();
    dcache_data_ok = 1'b0; req_valid = 2'b00; step();

    // backpressure on addr_ok
    set_slot(1, 1'b0, 32'h3000, 32'd0, 4'h0); req_valid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_dvalid", 32'(dcache_valid), 32'd1);
      chk("bp_addr",   dcache_addr,       32'h3000);
      step();
    end
    dcache_addr_ok = 1'b1; step();
    dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'h0BADF00D; step();
    dcache_data_ok = 1'b0; req_valid = 2'b00;
    chk("bp_no_dup", 32'(dcache_valid), 32'd0);
    step();

    // flush while slot 1 is in REQ: served clears, slot 0 is issued again
    set_slot(0, 1'b0, 32'h4000, 32'd0, 4'h0);
    set_slot(1, 1'b0, 32'h4004, 32'd0, 4'h0);
    req_valid = 2'b11;
    step();
    dcache_addr_ok = 1'b1; step();
    dcache_addr_ok = 1'b0; dcache_data_ok = 1'b1; dcache_rdata = 32'h44; step();
    dcache_data_ok = 1'b0;
    chk("fr_slot1_addr", dcache_addr, 32'h4004);
    flush = 1'b1; #1;
    chk("fr_no_done", 32'(req_done), 32'd0);
    step();
    flush = 1'b0;
    chk("fr_dvalid_low", 32'(dcache_valid), 32'd0);
    step();
    chk("fr_reissue_dvalid", 32'(dcache_valid), 32'd1);
    chk("fr_reissue_addr",   dcache_addr,       32'h4000);
    finish_group(20);
    step();

    // flush while in WAIT: the late data_ok is discarded, the next access waits for it
    set_slot(0, 1'b1, 32'h5000, 32'h55, 4'hF); req_valid = 2'b01;
    step();
    dcache_addr_ok = 1'b1; step();
    dcache_addr_ok = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    set_slot(0, 1'b0, 32'h6000, 32'd0, 4'h0); req_valid = 2'b01; #1;
    chk("fw_drain_pause", 32'(pause_arb),    32'd1);
    chk("fw_dvalid0",     32'(dcache_valid), 32'd0);
    step();
    step();
    dcache_data_ok = 1'b1; dcache_rdata = 32'hBAD; #1;
    chk("fw_no_done", 32'(req_done), 32'd0);
    step();
    dcache_data_ok = 1'b0;
    chk("fw_idle_dvalid", 32'(dcache_valid), 32'd0);
    step();
    chk("fw_next_dvalid", 32'(dcache_valid), 32'd1);
    chk("fw_next_addr",   dcache_addr,       32'h6000);
    finish_group(20);
    step();

    // randomized groups, flushes and cache latency
    for (int c = 0; c < 800; c++) begin
      if (m_chg) begin
        req_valid = 2'($urandom_range(0, 3));
        for (int s = 0; s < 2; s++)
          set_slot(s, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      flush          = ($urandom_range(0, 15) == 0);
      dcache_addr_ok = dcache_valid && ($urandom_range(0, 2) != 0);
      dcache_data_ok = m_out && ($urandom_range(0, 2) != 0);
      dcache_rdata   = $urandom;
      step();
    end
    finish_group(40);
    step();

`ifdef DCACHE_ARB_PERF_EN
    chk("perf_dual",  perf_dual_cnt,  32'(m_dual));
    chk("perf_stall", perf_stall_cnt, 32'(m_stall));
`else
    chk("perf_dual_off",  perf_dual_cnt,  32'd0);
    chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif

    // reset in the middle of an access
    set_slot(0, 1'b0, 32'h7000, 32'd0, 4'h0); req_valid = 2'b01;
    step();
    dcache_addr_ok = 1'b1; step();
    dcache_addr_ok = 1'b0;
    rst = 1'b0; #1;
    chk("mid_rst_dvalid", 32'(dcache_valid), 32'd0);
    chk("mid_rst_addr",   dcache_addr,       32'd0);
    chk("mid_rst_done",   32'(req_done),     32'd0);
    chk("mid_rst_pstall", perf_stall_cnt,    32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    step();
    chk("post_rst_reissue", dcache_addr, 32'h7000);
    finish_group(20);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
